// File: rtl/prog_run_if.sv
// rtl/prog_run_if.sv - run controller handshake and PC control bundle
interface prog_run_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             start;
    logic [1:0]       prog_sel;
    logic             halt;
    logic             stall_req;
    logic             count_en;
    logic             pc_load;
    logic [PC_W-1:0]  pc_target;
    logic             ack;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, prog_sel, halt, stall_req,
        input  count_en, pc_load, pc_target, ack, timeout, cycle_count
    );

    modport slave (
        input  start, prog_sel, halt, stall_req,
        output count_en, pc_load, pc_target, ack, timeout, cycle_count
    );
endinterface

// File: rtl/prog_run_ctrl.sv
// rtl/prog_run_ctrl.sv - start/load/run/halt/done sequencer with cycle counter and watchdog
module prog_run_ctrl #(
    parameter int              PC_W    = 10,
    parameter int              CNT_W   = 16,
    parameter int              TIMEOUT = 4096,
    parameter logic [PC_W-1:0] BASE0   = PC_W'(0),
    parameter logic [PC_W-1:0] BASE1   = PC_W'(256),
    parameter logic [PC_W-1:0] BASE2   = PC_W'(512),
    parameter logic [PC_W-1:0] BASE3   = PC_W'(768)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    prog_run_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic             pc_load_q, pc_load_d;
    logic [PC_W-1:0]  pc_target_q, pc_target_d;
    logic             ack_q, ack_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

    function automatic logic [PC_W-1:0] base_addr(input logic [1:0] s);
        case (s)
            2'd0:    return BASE0;
            2'd1:    return BASE1;
            2'd2:    return BASE2;
            default: return BASE3;
        endcase
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            sel_q         <= 2'd0;
            pc_load_q     <= 1'b0;
            pc_target_q   <= '0;
            ack_q         <= 1'b0;
            timeout_q     <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            pc_load_q     <= pc_load_d;
            pc_target_q   <= pc_target_d;
            ack_q         <= ack_d;
            timeout_q     <= timeout_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        pc_load_d     = 1'b0;
        pc_target_d   = pc_target_q;
        ack_d         = ack_q;
        timeout_d     = timeout_q;
        cycle_count_d = cycle_count_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (bus.start) begin
                    sel_d = bus.prog_sel;
                end else begin
                    state_d       = S_LOAD;
                    pc_load_d     = 1'b1;
                    pc_target_d   = base_addr(sel_q);
                    cycle_count_d = '0;
                    ack_d         = 1'b0;
                    timeout_d     = 1'b0;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                // Abort outranks halt and watchdog; an aborted cycle is not counted.
                if (bus.start) begin
                    state_d = S_ARMED;
                end else begin
                    cycle_count_d = cycle_count_q + 1'b1;
                    if (bus.halt && !bus.stall_req) begin
                        state_d = S_DONE;
                        ack_d   = 1'b1;
                    end else if (cycle_count_q == WDOG_LAST) begin
                        state_d   = S_DONE;
                        ack_d     = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    state_d   = S_ARMED;
                    ack_d     = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A halt instruction must not let the PC step past itself, hence the Halt term.
    assign bus.count_en    = (state_q == S_RUN) && !bus.stall_req
                             && !(bus.halt && !bus.stall_req);
    assign bus.pc_load     = pc_load_q;
    assign bus.pc_target   = pc_target_q;
    assign bus.ack         = ack_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cycle_count_q;
endmodule
